// File: rtl/core_pkg.sv
// core_pkg: shared ISA widths, ImmSrc encodings and the immediate-extend rule
package core_pkg;
  localparam int INSTR_IMM_W = 24;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    IMM8     = 2'b00,
    IMM12    = 2'b01,
    IMM24_BR = 2'b10,
    IMM_RSVD = 2'b11
  } imm_src_e;
  // Reserved encoding yields zero so the datapath never sees X
  function automatic logic [XLEN-1:0] extend_imm(input logic [INSTR_IMM_W-1:0] instr,
                                                 input logic [1:0] src);
    case (imm_src_e'(src))
      IMM8:     extend_imm = {24'b0, instr[7:0]};
      IMM12:    extend_imm = {20'b0, instr[11:0]};
      IMM24_BR: extend_imm = {{6{instr[23]}}, instr, 2'b00};
      default:  extend_imm = '0;
    endcase
  endfunction
endpackage

// File: rtl/extend.sv
// extend: immediate extender with a registered copy and valid/illegal flags
module extend
  import core_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_IMM_W-1:0] Instr,
  input  logic [1:0]             ImmSrc,
  input  logic                   in_valid,
  output logic [XLEN-1:0]        ExtImm,
  output logic [XLEN-1:0]        ExtImm_q,
  output logic                   valid_q,
  output logic                   illegal,
  output logic                   illegal_q
);
  logic [XLEN-1:0] ext_imm_d;
  logic            valid_d;
  logic            illegal_d;
  // Zero-latency extend path plus next-state for the registered copy
  always_comb begin
    ExtImm    = extend_imm(Instr, ImmSrc);
    illegal   = ImmSrc == IMM_RSVD;
    ext_imm_d = in_valid ? ExtImm : ExtImm_q;
    valid_d   = in_valid;
    illegal_d = in_valid & illegal;
  end
  // Registered stage; held value survives invalid cycles, reset clears at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ExtImm_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ExtImm_q  <= ext_imm_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_extend.sv
// tb_extend: randomized self-checking bench for extend against an arithmetic model
module tb_extend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] Instr;
  logic [1:0]  ImmSrc;
  logic        in_valid;
  logic [31:0] ExtImm, ExtImm_q;
  logic        valid_q, illegal, illegal_q;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_q;
  logic        m_v, m_i;

  extend dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .ExtImm(ExtImm), .ExtImm_q(ExtImm_q), .valid_q(valid_q),
    .illegal(illegal), .illegal_q(illegal_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field value scaled by plain arithmetic: unsigned field, or signed words times 4
  function automatic logic [31:0] model(input logic [23:0] ins, input logic [1:0] src);
    longint v;
    case (src)
      2'd0: v = ins % 256;
      2'd1: v = ins % 4096;
      2'd2: v = (ins >= 24'h800000 ? longint'(ins) - 64'sd16777216 : longint'(ins)) * 4;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, ".ext"}, ExtImm, model(Instr, ImmSrc));
    chk({tag, ".ill"}, {31'b0, illegal}, {31'b0, ImmSrc == 2'd3});
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".q"}, ExtImm_q, m_q);
    chk({tag, ".vq"}, {31'b0, valid_q}, {31'b0, m_v});
    chk({tag, ".iq"}, {31'b0, illegal_q}, {31'b0, m_i});
  endtask

  // Apply one input set, check the combinational path, clock it and check the registers
  task automatic step(input string tag, input logic v, input logic [1:0] src, input logic [23:0] ins);
    in_valid = v; ImmSrc = src; Instr = ins;
    #1 check_comb(tag);
    @(posedge clk);
    if (v) m_q = model(ins, src);
    m_v = v;
    m_i = v && src == 2'd3;
    #1 check_regs(tag);
  endtask

  logic [1:0]  d_src [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [23:0] d_ins [9] = '{24'h0000FF, 24'h00000A, 24'hFFFF80, 24'h000FFF, 24'hABCFFF,
                             24'h000100, 24'hFFFFFF, 24'h800000, 24'h000000};
  logic [31:0] d_exp [9] = '{32'h000000FF, 32'h0000000A, 32'h00000080, 32'h00000FFF,
                             32'h00000FFF, 32'h00000400, 32'hFFFFFFFC, 32'hFE000000, 32'h0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ImmSrc = 2'd0; Instr = 24'h0;
    m_q = '0; m_v = 1'b0; m_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ImmSrc = d_src[i]; Instr = d_ins[i];
      #1 chk($sformatf("dir%0d.ext", i), ExtImm, d_exp[i]);
      chk($sformatf("dir%0d.ill", i), {31'b0, illegal}, {31'b0, d_src[i] == 2'd3});
    end
    chk("rsvd.noX", {31'b0, $isunknown({ExtImm, illegal, ExtImm_q, valid_q, illegal_q})}, 32'd0);
    @(posedge clk); #1;
    step("reg_load", 1'b1, 2'd2, 24'h000100);
    chk("reg_load.abs", ExtImm_q, 32'h00000400);
    step("reg_hold", 1'b0, 2'd0, 24'h123456);
    chk("reg_hold.abs", ExtImm_q, 32'h00000400);
    step("reg_ill", 1'b1, 2'd3, 24'h5A5A5A);
    step("reg_ill_off", 1'b0, 2'd3, 24'h5A5A5A);
    for (int i = 0; i < 60; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom));
    step("pre_rst", 1'b1, 2'd2, 24'hFFFFFF);
    in_valid = 1'b1; ImmSrc = 2'd3; Instr = 24'h0;
    #2 rst_n = 1'b0;
    m_q = '0; m_v = 1'b0; m_i = 1'b0;
    #1 check_regs("async_rst");
    check_comb("rst_comb");
    @(posedge clk); #1 check_regs("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_q = '0; m_v = 1'b0; m_i = 1'b0;
    for (int i = 0; i < 3; i++)
      step($sformatf("post_rst%0d", i), 1'b1, 2'($urandom_range(0, 2)), 24'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
